// File: rtl/mem_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// FSM state encodings, cache mode constant and a saturating counter helper.
package mem_cache_ctrl_pkg;

    localparam int CACHE_MODE_DIRECT = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_HIT  = 3'd1,
        ST_MEM_RD  = 3'd2,
        ST_FILL    = 3'd3,
        ST_MEM_WR  = 3'd4,
        ST_WR_DONE = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/mem_cache_ctrl_if.sv
// CPU load/store handshake plus word-memory bus of the cache controller.
// master = controller side, slave = CPU/memory environment side.
interface mem_cache_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        flush;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_wdone;
    logic        memRead;
    logic        memWrite;
    logic [31:0] location;
    logic [31:0] value;
    logic [31:0] mem_out;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_out,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_wdone,
               memRead, memWrite, location, value, hit_cnt, miss_cnt
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_out,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_wdone,
               memRead, memWrite, location, value, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/mem_cache_ctrl_tag_array.sv
// One-word-per-line tag/data store: combinational read, single write port,
// valid bits cleared by async reset or synchronous flush.
module mem_cache_ctrl_tag_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);
    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [31:0]      data_r [LINES];

    // Valid bits: a flush wipes every line, a write marks its line valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (flush) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Tag and data payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_data  = data_r[rd_index];

endmodule

// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between the
// CPU load/store path and a word memory with fixed access latency MEM_LAT.
module mem_cache_ctrl
    import mem_cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 4,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_cache_ctrl_if.master  bus
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    logic               ready_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [31:0]        wdata_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               mem_read_r;
    logic               mem_write_r;
    logic [31:0]        location_r;
    logic [31:0]        value_r;
    logic               rvalid_r;
    logic [31:0]        rdata_r;
    logic               wdone_r;
    logic [15:0]        hit_cnt_r;
    logic [15:0]        miss_cnt_r;

    logic               ready_s;
    logic               accept_s;
    logic               flush_s;
    logic [INDEX_W-1:0] rd_index_s;
    logic [TAG_W-1:0]   cmp_tag_s;
    logic               rd_valid_s;
    logic [TAG_W-1:0]   rd_tag_s;
    logic [31:0]        rd_data_s;
    logic               hit_s;
    logic               wr_en_s;
    logic [31:0]        wr_data_s;
    logic               unused_s;

    assign unused_s = ^bus.cpu_addr[31:ADDR_W];

    // ready_r tracks "FSM is in IDLE" but is 0 during reset, so ready stays low until released.
    assign ready_s  = ready_r & ~bus.flush;
    assign accept_s = bus.cpu_req & ready_s;
    assign flush_s  = bus.flush & (state_r == ST_IDLE);

    // Lookup uses the live CPU address while idle, the latched one otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            rd_index_s = bus.cpu_addr[INDEX_W-1:0];
            cmp_tag_s  = bus.cpu_addr[ADDR_W-1:INDEX_W];
        end else begin
            rd_index_s = addr_r[INDEX_W-1:0];
            cmp_tag_s  = addr_r[ADDR_W-1:INDEX_W];
        end
    end

    assign hit_s = rd_valid_s & (rd_tag_s == cmp_tag_s);

    // Line writes: fill after a read miss, or update on the last cycle of a store hit.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = wdata_r;
        if (state_r == ST_FILL) begin
            wr_en_s   = 1'b1;
            wr_data_s = rdata_r;
        end else if ((state_r == ST_MEM_WR) && (cnt_r == CNT_ONE)) begin
            wr_en_s   = hit_s;
            wr_data_s = wdata_r;
        end else begin
            wr_en_s   = 1'b0;
            wr_data_s = wdata_r;
        end
    end

    mem_cache_ctrl_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_s),
        .rd_index (rd_index_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (wr_en_s),
        .wr_index (addr_r[INDEX_W-1:0]),
        .wr_tag   (addr_r[ADDR_W-1:INDEX_W]),
        .wr_data  (wr_data_s)
    );

    // Controller FSM with all bus/CPU outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'd0;
            cnt_r       <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            location_r  <= 32'd0;
            value_r     <= 32'd0;
            rvalid_r    <= 1'b0;
            rdata_r     <= 32'd0;
            wdone_r     <= 1'b0;
            hit_cnt_r   <= 16'd0;
            miss_cnt_r  <= 16'd0;
        end else begin
            rvalid_r <= 1'b0;
            wdone_r  <= 1'b0;
            ready_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r  <= bus.cpu_addr[ADDR_W-1:0];
                        wdata_r <= bus.cpu_wdata;
                        if (bus.cpu_we) begin
                            state_r     <= ST_MEM_WR;
                            mem_write_r <= 1'b1;
                            location_r  <= 32'(bus.cpu_addr[ADDR_W-1:0]);
                            value_r     <= bus.cpu_wdata;
                            cnt_r       <= LAT_LOAD;
                        end else if (hit_s) begin
                            state_r   <= ST_RD_HIT;
                            rvalid_r  <= 1'b1;
                            rdata_r   <= rd_data_s;
                            hit_cnt_r <= sat_inc16(hit_cnt_r);
                        end else begin
                            state_r    <= ST_MEM_RD;
                            mem_read_r <= 1'b1;
                            location_r <= 32'(bus.cpu_addr[ADDR_W-1:0]);
                            cnt_r      <= LAT_LOAD;
                            miss_cnt_r <= sat_inc16(miss_cnt_r);
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_RD_HIT: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                ST_MEM_RD: begin
                    if (cnt_r == CNT_ONE) begin
                        state_r    <= ST_FILL;
                        mem_read_r <= 1'b0;
                        rdata_r    <= bus.mem_out;
                        rvalid_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_FILL: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                ST_MEM_WR: begin
                    if (cnt_r == CNT_ONE) begin
                        state_r     <= ST_WR_DONE;
                        mem_write_r <= 1'b0;
                        wdone_r     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_WR_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ready  = ready_s;
    assign bus.cpu_rvalid = rvalid_r;
    assign bus.cpu_rdata  = rdata_r;
    assign bus.cpu_wdone  = wdone_r;
    assign bus.memRead    = mem_read_r;
    assign bus.memWrite   = mem_write_r;
    assign bus.location   = location_r;
    assign bus.value      = value_r;
    assign bus.hit_cnt    = hit_cnt_r;
    assign bus.miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed bench for mem_cache_ctrl: behavioural 256x32 word memory plus
// hand-computed expectations for hits, misses, stores, flush and async reset.
module tb_mem_cache_ctrl;

    logic clk;
    logic rst_n;
    mem_cache_ctrl_if bus ();

    mem_cache_ctrl #(
        .ADDR_W  (8),
        .INDEX_W (4),
        .MEM_LAT (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [256];
    int          vectors;
    int          miscompares;
    int          rd_total;
    int          wr_total;
    int          both_total;
    logic [31:0] rd_loc;
    logic [31:0] wr_loc;
    logic [31:0] wr_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_out = mem[bus.location[7:0]];

    // Memory model and strobe monitor.
    always @(posedge clk) begin
        if (bus.memRead) begin
            rd_total = rd_total + 1;
            rd_loc   = bus.location;
        end
        if (bus.memWrite) begin
            wr_total = wr_total + 1;
            wr_loc   = bus.location;
            wr_val   = bus.value;
            mem[bus.location[7:0]] = bus.value;
        end
        if (bus.memRead && bus.memWrite) begin
            both_total = both_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                           input int exp_lat, input int exp_rd);
        int lat;
        int rd0;
        bit got;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, bus.cpu_ready}, 32'd1);
        rd0 = rd_total;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = a;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat = lat + 1;
            if (bus.cpu_rvalid) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, bus.cpu_rdata, exp_d);
        chk({tag, "_rdcyc"}, 32'(rd_total - rd0), 32'(exp_rd));
        if (exp_rd != 0) chk({tag, "_rdloc"}, rd_loc, {24'd0, a[7:0]});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, bus.cpu_rvalid}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d);
        int lat;
        int wr0;
        int rd0;
        bit got;
        @(negedge clk);
        wr0 = wr_total;
        rd0 = rd_total;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat = lat + 1;
            if (bus.cpu_wdone) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_wrcyc"}, 32'(wr_total - wr0), 32'd2);
        chk({tag, "_rdcyc"}, 32'(rd_total - rd0), 32'd0);
        chk({tag, "_loc"}, wr_loc, {24'd0, a[7:0]});
        chk({tag, "_val"}, wr_val, d);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rd_total = 0;
        wr_total = 0;
        both_total = 0;
        rd_loc = 32'd0;
        wr_loc = 32'd0;
        wr_val = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        mem[8'h05] = 32'h0000_00A5;
        mem[8'h15] = 32'h0000_1515;
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.flush = 1'b0;

        #22;
        chk("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
        chk("rst_memrd", {31'd0, bus.memRead}, 32'd0);
        chk("rst_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_hits", {16'd0, bus.hit_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: cold miss, upper address bits ignored
        do_load("t1_miss", 32'hFF00_0005, 32'h0000_00A5, 3, 2);
        chk("t1_misscnt", {16'd0, bus.miss_cnt}, 32'd1);
        // 2: hit
        do_load("t2_hit", 32'h0000_0005, 32'h0000_00A5, 1, 0);
        chk("t2_hitcnt", {16'd0, bus.hit_cnt}, 32'd1);
        // 3: store hit updates line and memory
        do_store("t3_st", 32'h0000_0005, 32'h0000_1234);
        chk("t3_mem", mem[8'h05], 32'h0000_1234);
        do_load("t3_hit", 32'h0000_0005, 32'h0000_1234, 1, 0);
        chk("t3_hitcnt", {16'd0, bus.hit_cnt}, 32'd2);
        // 4: conflict eviction
        do_load("t4_evict", 32'h0000_0015, 32'h0000_1515, 3, 2);
        do_load("t4_remiss", 32'h0000_0005, 32'h0000_1234, 3, 2);
        chk("t4_misscnt", {16'd0, bus.miss_cnt}, 32'd3);
        // 5: store miss does not allocate
        do_store("t5_st", 32'h0000_0040, 32'h0000_CAFE);
        do_load("t5_noalloc", 32'h0000_0040, 32'h0000_CAFE, 3, 2);
        chk("t5_misscnt", {16'd0, bus.miss_cnt}, 32'd4);
        // 5b: flush beats a simultaneous request
        @(negedge clk);
        bus.flush = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'h0000_0005;
        #1 chk("t5_flush_ready", {31'd0, bus.cpu_ready}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.cpu_req = 1'b0;
        chk("t5_flush_noacc", {31'd0, bus.memRead}, 32'd0);
        do_load("t5_postflush", 32'h0000_0005, 32'h0000_1234, 3, 2);
        chk("t5_misscnt2", {16'd0, bus.miss_cnt}, 32'd5);
        chk("t5_hitcnt", {16'd0, bus.hit_cnt}, 32'd2);

        // 6: async reset in the middle of a memory read
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'h0000_0015;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("t6_rd_active", {31'd0, bus.memRead}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rd_drop", {31'd0, bus.memRead}, 32'd0);
        chk("t6_loc_zero", bus.location, 32'd0);
        chk("t6_miss_zero", {16'd0, bus.miss_cnt}, 32'd0);
        chk("t6_hit_zero", {16'd0, bus.hit_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_load("t6_miss", 32'h0000_0005, 32'h0000_1234, 3, 2);
        chk("t6_misscnt", {16'd0, bus.miss_cnt}, 32'd1);
        chk("t6_hitcnt", {16'd0, bus.hit_cnt}, 32'd0);

        chk("never_both_strobes", 32'(both_total), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
